// File: rtl/vdp_super_res_pkg.sv
// vdp_super_res_pkg
// Shared types and helpers for the super-res framebuffer write path.
//   wr_entry_t  : one buffered CPU byte write {byte pointer, palette index}
//   wr_state_t  : writer FSM states (GATHER exists only when
//                 SUPER_RES_WRITE_COALESCE_EN is defined)
//   lane_be()   : one-hot byte enable for a lane index
package vdp_super_res_pkg;

    localparam int unsigned SR_ADDR_W = 20;

    typedef struct packed {
        logic [SR_ADDR_W-1:0] addr;
        logic [7:0]           data;
    } wr_entry_t;

`ifdef SUPER_RES_WRITE_COALESCE_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        GATHER = 2'd2
    } wr_state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1
    } wr_state_t;
`endif

    function automatic logic [3:0] lane_be(input logic [1:0] k);
        return 4'b0001 << k;
    endfunction

endpackage

// File: rtl/vdp_super_res_wr_fifo.sv
// vdp_super_res_wr_fifo
// Synchronous first-word-fall-through FIFO with registered full/empty flags.
// Ports:
//   i_clk   : clock
//   i_clr   : synchronous flush (reset or block disabled)
//   i_push  : write i_data; accepted when not full, or when a pop happens too
//   i_data  : entry to write
//   i_pop   : remove head; ignored when empty
//   o_head  : current head entry (valid when !o_empty)
//   o_full  : registered, reflects state after the edge
//   o_empty : registered, reflects state after the edge
module vdp_super_res_wr_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter type         T     = logic [7:0]
) (
    input  logic i_clk,
    input  logic i_clr,
    input  logic i_push,
    input  T     i_data,
    input  logic i_pop,
    output T     o_head,
    output logic o_full,
    output logic o_empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T                 r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic [PTR_W:0]   w_count_next;
    logic             r_full;
    logic             r_empty;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_do_pop  = i_pop & ~r_empty;
    assign w_do_push = i_push & (~r_full | w_do_pop);

    always_comb begin
        w_count_next = r_count;
        if (w_do_push && !w_do_pop) begin
            w_count_next = r_count + (PTR_W + 1)'(1);
        end else if (w_do_pop && !w_do_push) begin
            w_count_next = r_count - (PTR_W + 1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_count_next;
            r_full  <= (w_count_next == (PTR_W + 1)'(DEPTH));
            r_empty <= (w_count_next == '0);
        end
    end

    // Storage needs no reset: contents are only visible through the flags.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/vdp_super_res_writer.sv
// vdp_super_res_writer
// Buffers CPU byte writes to the super-res framebuffer (8-bit palette indexes,
// 4 pixels per 32-bit VRAM word) and drains them to the VRAM arbiter write
// port as byte-enabled word writes, only while scan-out is not drawing.
// Optional build macro: SUPER_RES_WRITE_COALESCE_EN merges consecutive
// queued bytes that hit the same VRAM word into a single write.
// Ports:
//   i_clk, i_reset        : clock, synchronous active-high reset
//   i_vdp_super           : super mode enable; low holds the block idle/flushed
//   i_super_res_drawing   : scan-out owns the bus; no new requests while high
//   i_page_addr           : page base in 32-bit words
//   i_addr_set, i_addr_in : load the byte pointer (clears overflow)
//   i_data_wr, i_data_in  : push a palette index at the pointer, then advance
//   o_fifo_full/empty     : FIFO status
//   o_overflow            : sticky, a write was dropped
//   o_vram_wr_req/i_vram_wr_ack : request/accept handshake
//   o_vram_wr_addr/data/be      : word address, lane-replicated data, enables
module vdp_super_res_writer
    import vdp_super_res_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned ADDR_W     = SR_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_vdp_super,
    input  logic              i_super_res_drawing,
    input  logic [16:0]       i_page_addr,
    input  logic              i_addr_set,
    input  logic [ADDR_W-1:0] i_addr_in,
    input  logic              i_data_wr,
    input  logic [7:0]        i_data_in,
    output logic              o_fifo_full,
    output logic              o_fifo_empty,
    output logic              o_overflow,
    output logic              o_vram_wr_req,
    input  logic              i_vram_wr_ack,
    output logic [ADDR_W-3:0] o_vram_wr_addr,
    output logic [31:0]       o_vram_wr_data,
    output logic [3:0]        o_vram_wr_be
);

    localparam int unsigned WA_W = ADDR_W - 2;

    wr_state_t         r_state, w_state_d;
    logic [ADDR_W-1:0] r_ptr, w_ptr_d;
    logic              r_ovf, w_ovf_d;
    logic              r_req, w_req_d;
    logic [WA_W-1:0]   r_addr, w_addr_d;
    logic [31:0]       r_data, w_data_d;
    logic [3:0]        r_be, w_be_d;
`ifdef SUPER_RES_WRITE_COALESCE_EN
    logic [WA_W-1:0]   r_pend_word, w_pend_d;
`endif

    logic              w_clr;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    wr_entry_t         w_entry;
    wr_entry_t         w_head;
    logic [WA_W-1:0]   w_head_word;
    logic [WA_W-1:0]   w_head_vaddr;
    logic [3:0]        w_head_be;

    // Disabling super mode behaves exactly like reset.
    assign w_clr = i_reset | ~i_vdp_super;

    // addr_set has priority: a coincident data_wr is silently discarded.
    assign w_push  = i_data_wr & ~i_addr_set & (~w_full | w_pop);
    assign w_entry = '{addr: r_ptr, data: i_data_in};

    vdp_super_res_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (wr_entry_t)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_clr   (w_clr),
        .i_push  (w_push),
        .i_data  (w_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Word address uses page_addr as it stands when the entry is popped.
    assign w_head_word  = w_head.addr[ADDR_W-1:2];
    assign w_head_vaddr = WA_W'(i_page_addr) + w_head_word;
    assign w_head_be    = lane_be(w_head.addr[1:0]);

    // Pointer and sticky overflow.
    always_comb begin
        w_ptr_d = r_ptr;
        w_ovf_d = r_ovf;
        if (i_addr_set) begin
            w_ptr_d = i_addr_in;
            w_ovf_d = 1'b0;
        end else if (i_data_wr) begin
            if (w_push) w_ptr_d = r_ptr + ADDR_W'(1);
            else        w_ovf_d = 1'b1;
        end
    end

    // Drain FSM: next state, pop and payload.
    always_comb begin
        w_state_d = r_state;
        w_req_d   = r_req;
        w_addr_d  = r_addr;
        w_data_d  = r_data;
        w_be_d    = r_be;
        w_pop     = 1'b0;
`ifdef SUPER_RES_WRITE_COALESCE_EN
        w_pend_d  = r_pend_word;
`endif
        unique case (r_state)
            IDLE: begin
                if (!w_empty && !i_super_res_drawing) begin
                    w_pop    = 1'b1;
                    w_addr_d = w_head_vaddr;
                    w_data_d = {4{w_head.data}};
                    w_be_d   = w_head_be;
`ifdef SUPER_RES_WRITE_COALESCE_EN
                    w_pend_d  = w_head_word;
                    w_state_d = GATHER;
`else
                    w_req_d   = 1'b1;
                    w_state_d = REQ;
`endif
                end
            end
`ifdef SUPER_RES_WRITE_COALESCE_EN
            GATHER: begin
                if (!w_empty && w_head_word == r_pend_word && r_be != 4'hF) begin
                    w_pop  = 1'b1;
                    w_be_d = r_be | w_head_be;
                    for (int k = 0; k < 4; k++) begin
                        if (w_head_be[k]) w_data_d[8*k +: 8] = w_head.data;
                    end
                end else if (!i_super_res_drawing) begin
                    w_req_d   = 1'b1;
                    w_state_d = REQ;
                end
            end
`endif
            REQ: begin
                // Drawing rising here does not withdraw; the arbiter decides.
                if (i_vram_wr_ack) begin
                    w_req_d   = 1'b0;
                    w_state_d = IDLE;
                end
            end
            default: begin
                w_req_d   = 1'b0;
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_clr) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_ovf       <= 1'b0;
            r_req       <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_be        <= '0;
`ifdef SUPER_RES_WRITE_COALESCE_EN
            r_pend_word <= '0;
`endif
        end else begin
            r_state     <= w_state_d;
            r_ptr       <= w_ptr_d;
            r_ovf       <= w_ovf_d;
            r_req       <= w_req_d;
            r_addr      <= w_addr_d;
            r_data      <= w_data_d;
            r_be        <= w_be_d;
`ifdef SUPER_RES_WRITE_COALESCE_EN
            r_pend_word <= w_pend_d;
`endif
        end
    end

    assign o_fifo_full    = w_full;
    assign o_fifo_empty   = w_empty;
    assign o_overflow     = r_ovf;
    assign o_vram_wr_req  = r_req;
    assign o_vram_wr_addr = r_addr;
    assign o_vram_wr_data = r_data;
    assign o_vram_wr_be   = r_be;

endmodule

// File: tb/tb_vdp_super_res_writer.sv
// tb_vdp_super_res_writer
// Directed, self-checking bench for vdp_super_res_writer.
module tb_vdp_super_res_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vdp_super = 1'b0;
    logic        drawing = 1'b0;
    logic [16:0] page_addr = '0;
    logic        addr_set = 1'b0;
    logic [19:0] addr_in = '0;
    logic        data_wr = 1'b0;
    logic [7:0]  data_in = '0;
    logic        fifo_full, fifo_empty, overflow, wr_req;
    logic        wr_ack = 1'b0;
    logic [17:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;

    int n_tests = 0;
    int n_fail  = 0;

    vdp_super_res_writer #(
        .FIFO_DEPTH (8),
        .ADDR_W     (20)
    ) dut (
        .i_clk               (clk),
        .i_reset             (reset),
        .i_vdp_super         (vdp_super),
        .i_super_res_drawing (drawing),
        .i_page_addr         (page_addr),
        .i_addr_set          (addr_set),
        .i_addr_in           (addr_in),
        .i_data_wr           (data_wr),
        .i_data_in           (data_in),
        .o_fifo_full         (fifo_full),
        .o_fifo_empty        (fifo_empty),
        .o_overflow          (overflow),
        .o_vram_wr_req       (wr_req),
        .i_vram_wr_ack       (wr_ack),
        .o_vram_wr_addr      (wr_addr),
        .o_vram_wr_data      (wr_data),
        .o_vram_wr_be        (wr_be)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (wr_req !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk(tag, 32'(wr_req), 32'd1);
    endtask

    task automatic ack_pulse(input string tag);
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        chk(tag, 32'(wr_req), 32'd0);
    endtask

    task automatic write_byte(input logic [7:0] d);
        data_wr = 1'b1;
        data_in = d;
        tick();
        data_wr = 1'b0;
    endtask

    task automatic set_addr(input logic [19:0] a);
        addr_set = 1'b1;
        addr_in  = a;
        tick();
        addr_set = 1'b0;
    endtask

    task automatic chk_write(input string tag, input logic [17:0] a, input logic [31:0] d,
                             input logic [3:0] be);
        wait_req({tag, "_req"});
        chk({tag, "_addr"}, 32'(wr_addr), 32'(a));
        chk({tag, "_data"}, wr_data, d);
        chk({tag, "_be"}, 32'(wr_be), 32'(be));
        ack_pulse({tag, "_drop"});
    endtask

    initial begin
        logic saw_req;

        // Reset state.
        tick();
        tick();
        chk("rst_req", 32'(wr_req), 32'd0);
        chk("rst_empty", 32'(fifo_empty), 32'd1);
        chk("rst_full", 32'(fifo_full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_addr", 32'(wr_addr), 32'd0);
        chk("rst_data", wr_data, 32'd0);
        chk("rst_be", 32'(wr_be), 32'd0);
        reset     = 1'b0;
        vdp_super = 1'b1;
        tick();

        // Single write, minimum latency, payload held until ack.
        page_addr = 17'h00100;
        set_addr(20'h00005);
        write_byte(8'hAA);
        chk("t1_empty_after_push", 32'(fifo_empty), 32'd0);
        chk("t1_req_not_yet", 32'(wr_req), 32'd0);
        tick();
        chk("t1_req", 32'(wr_req), 32'd1);
        chk("t1_addr", 32'(wr_addr), 32'h101);
        chk("t1_data", wr_data, 32'hAAAAAAAA);
        chk("t1_be", 32'(wr_be), 32'b0010);
        tick();
        chk("t1_hold_req", 32'(wr_req), 32'd1);
        chk("t1_hold_addr", 32'(wr_addr), 32'h101);
        ack_pulse("t1_drop");
        chk("t1_empty", 32'(fifo_empty), 32'd1);

`ifndef SUPER_RES_WRITE_COALESCE_EN
        // Fill while drawing, overflow on the 9th, then drain in order.
        drawing = 1'b1;
        set_addr(20'h00000);
        for (int i = 0; i < 8; i++) write_byte(8'(i));
        chk("t2_full", 32'(fifo_full), 32'd1);
        chk("t2_no_req_drawing", 32'(wr_req), 32'd0);
        chk("t2_ovf_clear", 32'(overflow), 32'd0);
        write_byte(8'hFF);
        chk("t2_ovf", 32'(overflow), 32'd1);
        chk("t2_still_full", 32'(fifo_full), 32'd1);
        drawing = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk_write($sformatf("t2_w%0d", i), 18'h100 + 18'(i >> 2), {4{8'(i)}},
                      4'b0001 << (i & 3));
        end
        tick();
        chk("t2_empty", 32'(fifo_empty), 32'd1);
        chk("t2_no_extra_req", 32'(wr_req), 32'd0);
        // Dropped write left the pointer at 8.
        write_byte(8'h5A);
        chk_write("t2_after_drop", 18'h102, 32'h5A5A5A5A, 4'b0001);
        chk("t2_ovf_sticky", 32'(overflow), 32'd1);
`endif

        // addr_set wins over a coincident data_wr; then pointer wrap.
        page_addr = 17'h1FFFF;
        addr_set  = 1'b1;
        addr_in   = 20'hFFFFF;
        data_wr   = 1'b1;
        data_in   = 8'h77;
        tick();
        addr_set  = 1'b0;
        data_wr   = 1'b0;
        chk("t3_same_cycle_empty", 32'(fifo_empty), 32'd1);
        chk("t3_ovf_cleared", 32'(overflow), 32'd0);
        write_byte(8'hC1);
        write_byte(8'hC2);
        chk_write("t3_w0", 18'h1FFFE, 32'hC1C1C1C1, 4'b1000);
        chk_write("t3_w1", 18'h1FFFF, 32'hC2C2C2C2, 4'b0001);

        // Reset while a request awaits ack, with overflow set.
        page_addr = 17'h00100;
        drawing   = 1'b1;
        for (int i = 0; i < 9; i++) write_byte(8'h30 + 8'(i));
        chk("t4_ovf_pre", 32'(overflow), 32'd1);
        drawing = 1'b0;
        wait_req("t4_req_pre");
        reset = 1'b1;
        tick();
        chk("t4_req", 32'(wr_req), 32'd0);
        chk("t4_empty", 32'(fifo_empty), 32'd1);
        chk("t4_full", 32'(fifo_full), 32'd0);
        chk("t4_ovf", 32'(overflow), 32'd0);
        reset  = 1'b0;
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        tick();
        chk("t4_late_ack", 32'(wr_req), 32'd0);
        // Pointer was cleared by reset.
        write_byte(8'h9C);
        chk_write("t4_ptr0", 18'h100, 32'h9C9C9C9C, 4'b0001);

        // Super mode dropped with three entries queued.
        drawing = 1'b1;
        for (int i = 0; i < 3; i++) write_byte(8'hE0 + 8'(i));
        chk("t5_queued", 32'(fifo_empty), 32'd0);
        vdp_super = 1'b0;
        tick();
        chk("t5_flushed", 32'(fifo_empty), 32'd1);
        vdp_super = 1'b1;
        drawing   = 1'b0;
        saw_req   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (wr_req === 1'b1) saw_req = 1'b1;
        end
        chk("t5_no_req", 32'(saw_req), 32'd0);

`ifdef SUPER_RES_WRITE_COALESCE_EN
        // Four bytes of one word merge into a single write.
        drawing = 1'b1;
        set_addr(20'h00000);
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        write_byte(8'h44);
        drawing = 1'b0;
        chk_write("t6_merge", 18'h100, 32'h44332211, 4'b1111);
        saw_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (wr_req === 1'b1) saw_req = 1'b1;
        end
        chk("t6_single_write", 32'(saw_req), 32'd0);
        chk("t6_empty", 32'(fifo_empty), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
